// File: rtl/alu_pipelined_handshake_if.sv
// alu_pipelined_handshake_if: operand/opcode input handshake and result/flag output handshake
interface alu_pipelined_handshake_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   A;
  logic [DATA_WIDTH-1:0]   B;
  logic [OP_WIDTH-1:0]     alu_function;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] alu_result;
  logic                    carry_flag;
  logic                    zero_flag;
  logic                    div_by_zero;
  modport master (
    output in_valid, A, B, alu_function, out_ready,
    input  in_ready, out_valid, alu_result, carry_flag, zero_flag, div_by_zero
  );
  modport slave (
    input  in_valid, A, B, alu_function, out_ready,
    output in_ready, out_valid, alu_result, carry_flag, zero_flag, div_by_zero
  );
endinterface

// File: rtl/alu_pipelined_handshake.sv
// alu_pipelined_handshake: valid/ready ALU with registered results and an iterative restoring divider
module alu_pipelined_handshake #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
) (
  input logic clk,
  input logic reset,
  alu_pipelined_handshake_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_DIV  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_NAND = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_XNOR = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_CMP  = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_SHL  = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_SHR  = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_MOD  = OP_WIDTH'(13);

  typedef enum logic {IDLE, DIV_RUN} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mod_q, mod_d;
  logic            out_valid_q, out_valid_d;
  logic [2*W-1:0]  res_q, res_d;
  logic            carry_q, carry_d, zero_q, zero_d, dbz_q, dbz_d;

  logic [W:0]      sum, dif, shf;
  logic [1:0]      cmp;
  logic [2*W-1:0]  alu_r, res_n;
  logic            alu_c;
  logic            ge, run, in_ready, accept, is_div, b_zero, start_div, done, load;
  logic [W-1:0]    rem_nx, quo_nx;

  assign sum = {1'b0, bus.A} + {1'b0, bus.B};
  assign dif = {1'b0, bus.A} - {1'b0, bus.B};
  assign cmp = bus.A == bus.B ? 2'd1 : bus.A > bus.B ? 2'd2 : 2'd3;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (bus.alu_function)
      OP_ADD:  begin alu_r = {{(W-1){1'b0}}, sum}; alu_c = sum[W]; end
      OP_SUB:  begin alu_r = {{(W-1){1'b0}}, dif}; alu_c = dif[W]; end
      OP_MUL:  alu_r = {{W{1'b0}}, bus.A} * {{W{1'b0}}, bus.B};
      OP_DIV:  alu_r = {{W{1'b0}}, {W{1'b1}}};
      OP_AND:  alu_r = {{W{1'b0}}, bus.A & bus.B};
      OP_OR:   alu_r = {{W{1'b0}}, bus.A | bus.B};
      OP_NAND: alu_r = {{W{1'b0}}, ~(bus.A & bus.B)};
      OP_NOR:  alu_r = {{W{1'b0}}, ~(bus.A | bus.B)};
      OP_XOR:  alu_r = {{W{1'b0}}, bus.A ^ bus.B};
      OP_XNOR: alu_r = {{W{1'b0}}, ~(bus.A ^ bus.B)};
      OP_CMP:  alu_r = {{(2*W-2){1'b0}}, cmp};
      OP_SHL:  begin alu_r = {{(W-1){1'b0}}, bus.A, 1'b0}; alu_c = bus.A[W-1]; end
      OP_SHR:  begin alu_r = {{W{1'b0}}, bus.A >> 1}; alu_c = bus.A[0]; end
      OP_MOD:  alu_r = {{W{1'b0}}, bus.A};
      default: alu_r = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract when it fits
  assign shf    = {rem_q, quo_q[W-1]};
  assign ge     = shf >= {1'b0, dvs_q};
  assign rem_nx = ge ? W'(shf - {1'b0, dvs_q}) : shf[W-1:0];
  assign quo_nx = {quo_q[W-2:0], ge};

  assign run       = state_q == DIV_RUN;
  assign in_ready  = state_q == IDLE && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign is_div    = bus.alu_function == OP_DIV || bus.alu_function == OP_MOD;
  assign b_zero    = bus.B == '0;
  assign start_div = accept && is_div && !b_zero;
  assign done      = run && cnt_q == CW'(W - 1);
  assign load      = (accept && !start_div) || done;

  always_comb begin
    state_d     = start_div ? DIV_RUN : done ? IDLE : state_q;
    quo_d       = start_div ? bus.A : run ? quo_nx : quo_q;
    rem_d       = start_div ? '0 : run ? rem_nx : rem_q;
    dvs_d       = start_div ? bus.B : dvs_q;
    mod_d       = start_div ? bus.alu_function == OP_MOD : mod_q;
    cnt_d       = start_div ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    res_n       = done ? {{W{1'b0}}, mod_q ? rem_nx : quo_nx} : alu_r;
    out_valid_d = load || (out_valid_q && !bus.out_ready);
    res_d       = load ? res_n : res_q;
    carry_d     = load ? !done && alu_c : carry_q;
    zero_d      = load ? res_n == '0 : zero_q;
    dbz_d       = load ? !done && is_div && b_zero : dbz_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      mod_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      mod_q       <= mod_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_result  = res_q;
  assign bus.carry_flag  = carry_q;
  assign bus.zero_flag   = zero_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_pipelined_handshake.sv
// tb_alu_pipelined_handshake: scoreboard bench for the handshake ALU at W=8
module tb_alu_pipelined_handshake;
  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        d;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t mon_e;

  alu_pipelined_handshake_if #(.DATA_WIDTH(8), .OP_WIDTH(4)) bus ();
  alu_pipelined_handshake #(.DATA_WIDTH(8), .OP_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int   r;
    int   ai;
    int   bi;
    logic c;
    exp_t e;
    ai = a;
    bi = b;
    c  = 1'b0;
    case (op)
      4'd0:  begin r = ai + bi; c = r > 255; end
      4'd1:  begin r = (ai - bi) & 'h1FF; c = ai < bi; end
      4'd2:  r = ai * bi;
      4'd3:  r = bi == 0 ? 255 : ai / bi;
      4'd4:  r = ai & bi;
      4'd5:  r = ai | bi;
      4'd6:  r = ~(ai & bi) & 255;
      4'd7:  r = ~(ai | bi) & 255;
      4'd8:  r = ai ^ bi;
      4'd9:  r = ~(ai ^ bi) & 255;
      4'd10: r = ai == bi ? 1 : ai > bi ? 2 : 3;
      4'd11: begin r = ai << 1; c = a[7]; end
      4'd12: begin r = ai >> 1; c = a[0]; end
      4'd13: r = bi == 0 ? ai : ai % bi;
      default: r = 0;
    endcase
    e.r = r[15:0];
    e.c = c;
    e.z = r == 0;
    e.d = (op == 4'd3 || op == 4'd13) && bi == 0;
    return e;
  endfunction

  always @(negedge clk) begin
    #2;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        mon_e = q.pop_front();
        check("res", bus.alu_result, mon_e.r);
        check("flags_czd", {bus.carry_flag, bus.zero_flag, bus.div_by_zero}, {mon_e.c, mon_e.z, mon_e.d});
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input bit track);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.alu_function = op;
    #1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", n, 0);
    if (track) q.push_back(model(op, a, b));
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic wait_out(output int e, output int busy);
    e = 0;
    busy = 0;
    while (!bus.out_valid && e < 50) begin
      if (!bus.in_ready) busy++;
      @(negedge clk);
      #1;
      e++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int busy;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.alu_function = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.alu_result, 0);
    check("rst_flags", {bus.carry_flag, bus.zero_flag, bus.div_by_zero}, 0);

    send(4'd0, 8'h54, 8'h2A, 1);
    check("add_valid", bus.out_valid, 1);
    send(4'd0, 8'hF0, 8'h20, 1);
    send(4'd2, 8'h54, 8'h2A, 1);
    send(4'd1, 8'h2A, 8'h54, 1);
    send(4'd8, 8'hF4, 8'hF4, 1);

    send(4'd3, 8'h54, 8'h2A, 1);
    wait_out(e, busy);
    check("div_latency", e, 8);
    check("div_busy", busy, 8);
    send(4'd13, 8'h55, 8'h2A, 1);
    wait_out(e, busy);
    check("mod_latency", e, 8);
    send(4'd13, 8'hFF, 8'h07, 1);
    wait_out(e, busy);
    send(4'd3, 8'h54, 8'h00, 1);
    wait_out(e, busy);
    check("div0_latency", e, 0);
    send(4'd13, 8'h54, 8'h00, 1);
    wait_out(e, busy);
    check("mod0_latency", e, 0);

    for (int op = 4; op < 16; op++) begin
      send(4'(op), 8'hB5, 8'h5B, 1);
      send(4'(op), 8'h3C, 8'hC3, 1);
    end
    send(4'd10, 8'h22, 8'h22, 1);
    send(4'd11, 8'h41, 8'h00, 1);

    @(negedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(4'd5, 8'hF4, 8'h2C, 1);
    check("bp_valid", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.A = 8'h11;
    bus.B = 8'h22;
    bus.alu_function = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_res", bus.alu_result, 16'h00FC);
      check("bp_hold_flags", {bus.carry_flag, bus.zero_flag, bus.div_by_zero}, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_drained", bus.out_valid, 0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.A = 8'(i * 61 + 3);
      bus.B = 8'(i * 45 + 200);
      bus.alu_function = 4'd0;
      bus.in_valid = 1'b1;
      #1;
      check("burst_ready", bus.in_ready, 1);
      if (i > 0) check("burst_valid", bus.out_valid, 1);
      q.push_back(model(4'd0, bus.A, bus.B));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("burst_last_valid", bus.out_valid, 1);

    send(4'd3, 8'hC8, 8'h03, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_result", bus.alu_result, 0);
    check("abort_flags", {bus.carry_flag, bus.zero_flag, bus.div_by_zero}, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      check("no_stale", bus.out_valid, 0);
    end

    send(4'd0, 8'h01, 8'hFF, 1);
    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_pipelined_handshake.md
Name: alu_pipelined_handshake

Overview:
- Parametrised successor to the single-cycle enable-driven ALU.
- Accepts operations through a valid/ready input handshake and returns registered results through a valid/ready output handshake.
- Adds XOR/NAND/NOR/XNOR, shifts, compare and modulo, plus carry, zero and divide-by-zero status flags.
- DIV/MOD run on an iterative restoring divider over multiple cycles; all other ops complete in one cycle. The block sits between the system controller and the register file / UART TX path.

Parameters:
DATA_WIDTH, 8, operand width W; result width is 2W.
OP_WIDTH, 4, width of alu_function.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands and opcode presented.
in_ready  output  1  block can accept an operation this cycle.
A  input  DATA_WIDTH  operand A, unsigned.
B  input  DATA_WIDTH  operand B, unsigned.
alu_function  input  OP_WIDTH  opcode.
out_valid  output  1  alu_result and flags are valid.
out_ready  input  1  consumer takes the result.
alu_result  output  2*DATA_WIDTH  registered result.
carry_flag  output  1  carry/borrow/shift-out of the completed op.
zero_flag  output  1  alu_result == 0.
div_by_zero  output  1  DIV/MOD issued with B == 0.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - out_valid, alu_result, carry_flag, zero_flag and div_by_zero all go to 0.
  - Any divide in progress is aborted; no result is produced for it.
- Accept rule:
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - An operation is accepted on an edge where in_valid && in_ready.
  - A, B and alu_function are captured at that edge; later changes on the inputs have no effect.
- Output rule:
  - out_valid clears on an edge with out_valid && out_ready, unless a new result loads on the same edge. In that case out_valid stays 1 and the new result replaces the old one.
  - While out_valid && !out_ready, alu_result and all flags hold stable.
- Opcodes (W = DATA_WIDTH). Unless stated otherwise, results are zero-extended and carry_flag = 0.
  - 0000 ADD: result = A + B (W+1 bits); carry_flag = bit W.
  - 0001 SUB: result[W-1:0] = A - B mod 2^W; result[W] = borrow (A < B); carry_flag = borrow.
  - 0010 MUL: result = full 2W-bit product.
  - 0011 DIV: result = quotient.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR: bitwise on W bits.
  - 1010 CMP: result = 1 if A == B, 2 if A > B, 3 if A < B.
  - 1011 SHL: result = A << 1 (W+1 bits); carry_flag = A[W-1].
  - 1100 SHR: result = A >> 1; carry_flag = A[0].
  - 1101 MOD: result = remainder.
  - 1110, 1111: result = 0; out_valid is still produced.
- zero_flag is computed from the final alu_result and registered with it.
- Single-cycle ops: accepted at edge N, so out_valid = 1 and the result is visible after edge N; latency is 1 cycle.
- DIV/MOD with B != 0 (FSM IDLE -> DIV_RUN -> IDLE):
  - Accept edge N loads the divider and enters DIV_RUN; in_ready = 0 in DIV_RUN.
  - A counter runs W iterations on edges N+1 .. N+W.
  - The result loads on edge N+W, which sets out_valid; state returns to IDLE.
  - Latency is W cycles.
- DIV/MOD with B == 0:
  - No iteration; latency is 1 cycle.
  - DIV result = {W zeros, W ones}; MOD result = A.
  - div_by_zero = 1. div_by_zero is 0 for every other completed op.
- Simultaneous events:
  - A result loading while the previous result drains (out_ready = 1) is legal, giving back-to-back throughput of 1 op per cycle for single-cycle ops.
  - reset wins over every other event.

Test Plan:
1. W=8, ADD A=0x54 B=0x2A, out_ready=1 -> after 1 cycle: out_valid=1, alu_result=0x007E, carry_flag=0, zero_flag=0. Then ADD 0xF0+0x20 -> 0x0110, carry_flag=1.
2. MUL 0x54*0x2A -> 0x0DC8. SUB 0x2A-0x54 -> 0x01D6, carry_flag=1. XOR 0xF4^0xF4 -> 0x0000, zero_flag=1.
3. DIV 0x54/0x2A -> in_ready=0 for 8 cycles, out_valid after edge N+8, result 0x0002. MOD 0x55%0x2A -> 0x0001.
4. DIV A=0x54 B=0x00 -> latency 1, result 0x00FF, div_by_zero=1. MOD A=0x54 B=0x00 -> 0x0054, div_by_zero=1.
5. Backpressure: hold out_ready=0 after an OR 0xF4|0x2C (result 0x00FC) -> out_valid and result stay stable, in_ready=0, new in_valid ignored. Raise out_ready -> drains in 1 cycle; 5 back-to-back ADDs then complete 1 per cycle.
6. Assert reset for 1 cycle during DIV_RUN (iteration 4) -> next cycle: IDLE, in_ready=1, out_valid=0, all flags 0, no stale result ever emitted.
